// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: 4-deep FIFO controller in front of an external 4-entry,
// single-port register memory (combinational read, clocked write).
// One memory access per cycle. Writes and reads arbitrate with a toggling
// priority flag. A registered output word (rd_data) sits in front of the memory.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   wr_valid/wr_data    : producer side; wr_ready is combinational
//   rd_valid/rd_data    : consumer side (registered); rd_ready from consumer
//   mem_sel/mem_din/mem_ld/mem_dout : memory port
//   count               : words held in memory (0..4), rd_data excluded
//   full/empty          : count==4 / nothing in memory and rd_data invalid
module mem_fifo_ctrl #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    output logic [1:0]       mem_sel,
    output logic [WIDTH-1:0] mem_din,
    output logic             mem_ld,
    input  logic [WIDTH-1:0] mem_dout,
    output logic [2:0]       count,
    output logic             full,
    output logic             empty
);

    logic [1:0]       wptr_q, wptr_d;
    logic [1:0]       rptr_q, rptr_d;
    logic [2:0]       count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             prio_wr_q, prio_wr_d;

    logic wr_want, rd_want, wr_gnt, rd_gnt, conflict;

    // A read is wanted only when the output register is free or being emptied
    // this cycle, so rd_ready feeds straight through to wr_ready.
    assign wr_want  = wr_valid & (count_q != 3'd4);
    assign rd_want  = (count_q != 3'd0) & (~rd_valid_q | rd_ready);
    assign conflict = wr_want & rd_want;
    assign wr_gnt   = wr_want & (~rd_want | prio_wr_q);
    assign rd_gnt   = rd_want & (~wr_want | ~prio_wr_q);

    assign wr_ready = (count_q != 3'd4) & (~rd_want | prio_wr_q);
    assign mem_ld   = wr_gnt;
    assign mem_sel  = wr_gnt ? wptr_q : rptr_q;
    assign mem_din  = wr_data;

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign full     = (count_q == 3'd4);
    assign empty    = (count_q == 3'd0) & ~rd_valid_q;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        prio_wr_d  = prio_wr_q;

        // The winner of a conflict yields priority at the next one.
        if (conflict)
            prio_wr_d = ~prio_wr_q;

        // Grants are mutually exclusive, so count moves by at most one.
        if (wr_gnt) begin
            wptr_d  = wptr_q + 2'd1;
            count_d = count_q + 3'd1;
        end else if (rd_gnt) begin
            rptr_d  = rptr_q + 2'd1;
            count_d = count_q - 3'd1;
        end

        if (rd_gnt) begin
            rd_data_d  = mem_dout;
            rd_valid_d = 1'b1;
        end else if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            prio_wr_q  <= 1'b1;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            prio_wr_q  <= prio_wr_d;
        end
    end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Bench for mem_fifo_ctrl: behavioural 4-entry memory, directed stimulus,
// scoreboard queue filled on write acceptance and drained by a monitor on
// every read handshake.
module tb_mem_fifo_ctrl;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_valid = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         wr_ready;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic         rd_ready = 1'b0;
    logic [1:0]   mem_sel;
    logic [W-1:0] mem_din;
    logic         mem_ld;
    logic [W-1:0] mem_dout;
    logic [2:0]   count;
    logic         full;
    logic         empty;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] mem[4];

    always #5 clk = ~clk;

    mem_fifo_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .mem_sel(mem_sel), .mem_din(mem_din), .mem_ld(mem_ld),
        .mem_dout(mem_dout), .count(count), .full(full), .empty(empty)
    );

    initial for (int i = 0; i < 4; i++) mem[i] = '0;
    always @(posedge clk) if (mem_ld) mem[mem_sel] <= mem_din;
    assign mem_dout = mem[mem_sel];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each read handshake must deliver the oldest accepted word.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_extra: got 0x%0h with nothing expected", rd_data);
            end else begin
                logic [W-1:0] e;
                e = sb.pop_front();
                pops++;
                if (rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_order: got 0x%0h expected 0x%0h", rd_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Offer a word and hold it until accepted; wr_valid is left high so
    // consecutive calls stream back to back.
    task automatic put(input logic [W-1:0] d);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        forever begin
            @(negedge clk);
            if (wr_ready) begin
                sb.push_back(d);
                break;
            end
            n++;
            if (n > 40) begin
                check("put_timeout", 0, 1);
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic drain();
        int n;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!empty && n < 60);
        check("drain_empty", int'(empty), 1);
        check("drain_sb", sb.size(), 0);
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        int p0;
        // Reset values
        #2;
        check("rst_count", int'(count), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_wr_ready", int'(wr_ready), 1);
        check("rst_mem_ld", int'(mem_ld), 0);
        check("rst_mem_sel", int'(mem_sel), 0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // Single word: write cycle, then read-grant cycle
        wr_valid = 1'b1; wr_data = 6'h15; rd_ready = 1'b0;
        @(negedge clk);
        check("w1_mem_sel", int'(mem_sel), 0);
        check("w1_mem_ld", int'(mem_ld), 1);
        check("w1_mem_din", int'(mem_din), 'h15);
        check("w1_wr_ready", int'(wr_ready), 1);
        sb.push_back(6'h15);
        tick();
        wr_valid = 1'b0;
        check("w1_count", int'(count), 1);
        check("w1_rd_valid0", int'(rd_valid), 0);
        @(negedge clk);
        check("w1_rdcyc_ld", int'(mem_ld), 0);
        tick();
        check("w1_rd_data", int'(rd_data), 'h15);
        check("w1_rd_valid", int'(rd_valid), 1);
        check("w1_count0", int'(count), 0);
        check("w1_empty", int'(empty), 0);
        drain();

        // Fill: 0x01 into rd_data, 0x02..0x05 in memory, 0x06 refused
        for (int i = 1; i <= 5; i++) put(W'(i));
        wr_valid = 1'b1; wr_data = 6'h06;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_wr_ready", int'(wr_ready), 0);
            check("full_flag", int'(full), 1);
            check("full_count", int'(count), 4);
            check("hold_rd_valid", int'(rd_valid), 1);
            check("hold_rd_data", int'(rd_data), 1);
            check("hold_mem_ld", int'(mem_ld), 0);
            tick();
        end

        // Release consumer with 0x06 still offered; order 1..6 must emerge
        rd_ready = 1'b1;
        put(6'h06);
        drain();

        // Ten words streamed with consumer always ready (pointers wrap)
        p0 = pops;
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) put(W'(6'h10 + i));
        drain();
        check("stream_pops", pops - p0, 10);

        // Reset with count=3 and rd_valid=1
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(W'(6'h21 + i));
        wr_valid = 1'b0;
        tick(); tick();
        check("pre_rst_count", int'(count), 3);
        check("pre_rst_rd_valid", int'(rd_valid), 1);
        wr_valid = 1'b1; wr_data = 6'h3F;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_rd_valid", int'(rd_valid), 0);
        check("mid_rst_rd_data", int'(rd_data), 0);
        check("mid_rst_empty", int'(empty), 1);
        sb.delete();
        wr_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick();
        put(6'h2A);
        wr_valid = 1'b0;
        tick();
        check("post_rst_rd_data", int'(rd_data), 'h2A);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_fifo_ctrl.md
MEM_FIFO_CTRL -- requirements
Module: mem_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the data width, which matches the 6-bit word of the 4-entry register memory it drives.
REQ-002 The block SHALL have a fixed depth of 4 entries, addressed by the 2-bit memory select; depth is not a parameter.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock, shared with the memory.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 wr_valid  in  1  producer offers wr_data.
REQ-007 wr_data  in  WIDTH  write word.
REQ-008 wr_ready  out  1  write accepted this cycle when wr_valid is also high.
REQ-009 rd_valid  out  1  rd_data holds a valid word.
REQ-010 rd_data  out  WIDTH  registered read word.
REQ-011 rd_ready  in  1  consumer takes rd_data when rd_valid is also high.
REQ-012 mem_sel  out  2  memory entry select.
REQ-013 mem_din  out  WIDTH  memory write data.
REQ-014 mem_ld  out  1  memory load strobe.
REQ-015 mem_dout  in  WIDTH  memory read data, combinational from mem_sel.
REQ-016 count  out  3  words held in memory, 0..4, excluding rd_data.
REQ-017 full  out  1  count==4.
REQ-018 empty  out  1  count==0 and rd_valid==0.

Function
REQ-019 The block SHALL operate as a 4-deep FIFO using a single-port memory, with at most one memory access (write or read) per cycle.
REQ-020 Internal state SHALL be: wptr[1:0], rptr[1:0], count[2:0], rd_valid, rd_data, and prio_wr (arbitration flag).
REQ-021 Write request: wr_want = wr_valid & (count!=4).
REQ-022 Read request: rd_want = (count!=0) & (~rd_valid | rd_ready).
REQ-023 Grant: the only requester wins; on conflict, write wins if prio_wr=1, otherwise read wins.
REQ-024 prio_wr SHALL toggle only on a conflict cycle, so the winner loses priority at the next conflict.
REQ-025 wr_ready = (count!=4) & (~rd_want | prio_wr); this is combinational and depends on rd_ready.
REQ-026 Write grant: mem_sel=wptr and mem_ld=1; at the clock edge the word is stored, wptr increments mod 4, and count increments.
REQ-027 Otherwise mem_ld=0 and mem_sel=rptr.
REQ-028 mem_din SHALL equal wr_data at all times.
REQ-029 Read grant: at the clock edge rd_data<=mem_dout, rd_valid<=1, rptr increments mod 4, and count decrements.
REQ-030 Handshake without a read grant: if rd_valid&rd_ready, then rd_valid<=0 and rd_data is held.
REQ-031 Latency: a word written at edge N SHALL be eligible for read grant in cycle N+1 and appear on rd_data after edge N+1 (minimum 2 edges from acceptance to rd_valid).
REQ-032 Full: wr_ready=0, and writes are blocked until a read grant occurs.
REQ-033 Empty memory: no read grant, and rd_valid drains by handshake only.
REQ-034 Pointer wrap: wptr and rptr wrap from 3 to 0; FIFO order SHALL be preserved across wrap.
REQ-035 Total occupancy (count + rd_valid) SHALL never exceed 5; words SHALL never be duplicated or dropped.
REQ-036 wr_valid with wr_ready=0 SHALL have no effect; the producer holds the word.
REQ-037 rd_valid SHALL remain high and rd_data stable until rd_ready.

Reset
REQ-038 On rst_n low, asynchronously: wptr=0, rptr=0, count=0, rd_valid=0, rd_data=0, prio_wr=1; hence mem_ld=0, mem_sel=0, full=0, empty=1, wr_ready=1.
REQ-039 A reset mid-operation SHALL discard all stored words; memory contents are not cleared but are unreachable.
REQ-040 A write in progress at reset assertion SHALL be lost.
REQ-041 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Verification
REQ-042 Reset then write 0x15 with rd_ready=0 -> mem_sel=0 and mem_ld=1 in that cycle; count=1; next cycle read grant; rd_data=0x15, rd_valid=1, count=0.
REQ-043 Write 0x01,0x02,0x03,0x04,0x05,0x06 back-to-back, rd_ready=0 -> 0x01 in rd_data; 0x02-0x05 stored (count=4, full=1); 0x06 held with wr_ready=0.
REQ-044 From the full state, set rd_ready=1 with wr_valid=1 -> grants alternate read/write each conflict; output sequence 0x01..0x06 in order; no loss.
REQ-045 Stream 10 words through with rd_ready=1 -> pointers wrap twice; output order matches input order.
REQ-046 Assert rst_n low with count=3 and rd_valid=1 -> immediately count=0, rd_valid=0, rd_data=0, empty=1; the next write of 0x2A reads back 0x2A.
REQ-047 Hold rd_ready=0 with rd_valid=1 for 5 cycles -> rd_data stable and no read grant.
